// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// Holds the state encoding, the one-hot owner codes and the counter-width helper.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOCK_M1 = 2'd1,
        ST_RECOVER = 2'd2
    } arb_state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_M0   = 2'b01;
    localparam logic [1:0] OWN_M1   = 2'b10;

    // Bits needed to hold values 0..max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous active-low reset, clear, load and increment.
// Priority is reset, then clear, then load, then increment.
module sat_counter #(
    parameter int unsigned W   = 4,
    parameter int unsigned MAX = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (inc && (cnt != W'(MAX))) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter: M0 (CPU) has fixed priority, M1 gets bounded
// starvation and locked bursts capped at BURST_MAX beats, followed by an M0 window.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned MAX_WAIT  = 4,
    parameter int unsigned BURST_MAX = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            m0_req,
    input  logic [AW-1:0]   m0_addr,
    input  logic [DW-1:0]   m0_wdata,
    input  logic [DW/8-1:0] m0_we,
    output logic [DW-1:0]   m0_rdata,
    output logic            m0_ack,
    output logic            m0_stall,
    input  logic            m1_req,
    input  logic            m1_lock,
    input  logic [AW-1:0]   m1_addr,
    input  logic [DW-1:0]   m1_wdata,
    input  logic [DW/8-1:0] m1_we,
    output logic [DW-1:0]   m1_rdata,
    output logic            m1_ack,
    output logic [AW-1:0]   s_daddr,
    output logic [DW-1:0]   s_dwdata,
    output logic [DW/8-1:0] s_dwe,
    input  logic [DW-1:0]   s_drdata,
    output logic [1:0]      owner
);

    localparam int unsigned WW = cnt_width(MAX_WAIT);
    localparam int unsigned BW = cnt_width(BURST_MAX);

    arb_state_t    state, state_nxt;
    logic [1:0]    grant;
    logic [WW-1:0] wait_cnt;
    logic [BW-1:0] beat_cnt;
    logic          lock_hold;
    logic          wait_hit;
    logic          beat_load, beat_inc, beat_clr;

    assign lock_hold = (state == ST_LOCK_M1) && m1_req && m1_lock;
    assign wait_hit  = (wait_cnt == WW'(MAX_WAIT));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Reset gates the grant, so no ack or write strobe can escape during reset.
    always_comb begin
        grant = OWN_NONE;
        if (!reset) begin
            grant = OWN_NONE;
        end else if (lock_hold) begin
            grant = OWN_M1;
        end else if ((state == ST_RECOVER) && m0_req) begin
            grant = OWN_M0;
        end else if (m0_req && m1_req) begin
            grant = wait_hit ? OWN_M1 : OWN_M0;
        end else if (m0_req) begin
            grant = OWN_M0;
        end else if (m1_req) begin
            grant = OWN_M1;
        end
    end

    assign m0_ack = grant[0];
    assign m1_ack = grant[1];

    always_comb begin
        state_nxt = state;
        beat_load = 1'b0;
        beat_inc  = 1'b0;
        beat_clr  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (m1_ack && m1_lock) begin
                    beat_load = 1'b1;
                    state_nxt = (BURST_MAX <= 1) ? ST_RECOVER : ST_LOCK_M1;
                end
            end
            ST_LOCK_M1: begin
                if (!lock_hold) begin
                    state_nxt = ST_RECOVER;
                end else begin
                    beat_inc = m1_ack;
                    // beat_cnt counts beats already done, so this ack is the last one.
                    if (beat_cnt == BW'(BURST_MAX - 1)) begin
                        state_nxt = ST_RECOVER;
                    end
                end
            end
            ST_RECOVER: begin
                beat_clr  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        owner    = grant;
        m0_stall = m0_req & ~m0_ack;
        s_daddr  = '0;
        s_dwdata = '0;
        s_dwe    = '0;
        m0_rdata = '0;
        m1_rdata = '0;
        if (grant == OWN_M0) begin
            s_daddr  = m0_addr;
            s_dwdata = m0_wdata;
            s_dwe    = m0_we;
            m0_rdata = s_drdata;
        end else if (grant == OWN_M1) begin
            s_daddr  = m1_addr;
            s_dwdata = m1_wdata;
            s_dwe    = m1_we;
            m1_rdata = s_drdata;
        end
    end

    sat_counter #(
        .W   (WW),
        .MAX (MAX_WAIT)
    ) u_wait_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (m1_ack | ~m1_req),
        .inc      (m1_req & ~m1_ack),
        .load     (1'b0),
        .load_val ('0),
        .cnt      (wait_cnt)
    );

    sat_counter #(
        .W   (BW),
        .MAX (BURST_MAX)
    ) u_beat_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (beat_clr),
        .inc      (beat_inc),
        .load     (beat_load),
        .load_val (BW'(1)),
        .cnt      (beat_cnt)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a byte-enabled dmem model.
// Inputs change 1 time unit after the rising edge; outputs are checked 4 units later.
module tb_dmem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic            clk;
    logic            reset;
    logic            m0_req, m1_req, m1_lock;
    logic [AW-1:0]   m0_addr, m1_addr;
    logic [DW-1:0]   m0_wdata, m1_wdata;
    logic [DW/8-1:0] m0_we, m1_we;
    logic [DW-1:0]   m0_rdata, m1_rdata;
    logic            m0_ack, m1_ack, m0_stall;
    logic [AW-1:0]   s_daddr;
    logic [DW-1:0]   s_dwdata;
    logic [DW/8-1:0] s_dwe;
    logic [DW-1:0]   s_drdata;
    logic [1:0]      owner;

    logic [31:0] mem [0:255];
    int unsigned checks = 0;
    int unsigned errors = 0;

    dmem_arbiter #(
        .AW        (AW),
        .DW        (DW),
        .MAX_WAIT  (4),
        .BURST_MAX (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .m0_req   (m0_req),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_we    (m0_we),
        .m0_rdata (m0_rdata),
        .m0_ack   (m0_ack),
        .m0_stall (m0_stall),
        .m1_req   (m1_req),
        .m1_lock  (m1_lock),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_we    (m1_we),
        .m1_rdata (m1_rdata),
        .m1_ack   (m1_ack),
        .s_daddr  (s_daddr),
        .s_dwdata (s_dwdata),
        .s_dwe    (s_dwe),
        .s_drdata (s_drdata),
        .owner    (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign s_drdata = mem[s_daddr[9:2]];

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (s_dwe[b]) mem[s_daddr[9:2]][b*8 +: 8] <= s_dwdata[b*8 +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    int unsigned beat;
    logic exp_m1;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[64] = 32'h1122_3344;
        mem[16] = 32'hDEAD_BEEF;
        mem[4]  = 32'h1234_5678;

        // Reset held with both masters writing to 0x100.
        reset    = 1'b0;
        m0_req   = 1'b1; m0_addr = 32'h100; m0_wdata = 32'hAAAA_AAAA; m0_we = 4'hF;
        m1_req   = 1'b1; m1_lock = 1'b1; m1_addr = 32'h100; m1_wdata = 32'hBBBB_BBBB; m1_we = 4'hF;
        for (int c = 0; c < 10; c++) begin
            settle();
            check("rst_dwe", s_dwe, 4'h0);
            check("rst_m0_ack", m0_ack, 1'b0);
            check("rst_m1_ack", m1_ack, 1'b0);
            check("rst_owner", owner, 2'b00);
            check("rst_stall", m0_stall, 1'b1);
            next_cycle();
        end
        check("rst_mem100", mem[64], 32'h1122_3344);

        // Lone M1 read.
        reset  = 1'b1;
        m0_req = 1'b0; m0_we = 4'h0;
        m1_req = 1'b1; m1_lock = 1'b0; m1_addr = 32'h40; m1_we = 4'h0;
        settle();
        check("m1rd_ack", m1_ack, 1'b1);
        check("m1rd_rdata", m1_rdata, 32'hDEAD_BEEF);
        check("m1rd_m0_rdata", m0_rdata, 32'h0);
        check("m1rd_owner", owner, 2'b10);
        check("m1rd_stall", m0_stall, 1'b0);
        next_cycle();

        // Both reading continuously: M1 forced in on every fifth cycle.
        m0_req = 1'b1; m0_addr = 32'h10;
        for (int c = 0; c < 10; c++) begin
            settle();
            exp_m1 = (c == 4) || (c == 9);
            check("fair_m0_ack", m0_ack, !exp_m1);
            check("fair_m1_ack", m1_ack, exp_m1);
            check("fair_stall", m0_stall, exp_m1);
            next_cycle();
        end
        m0_req = 1'b0; m1_req = 1'b0;
        next_cycle();

        // M0 byte-lane write concurrent with an M1 read.
        m0_req = 1'b1; m0_addr = 32'h10; m0_wdata = 32'h0000_AB00; m0_we = 4'b0010;
        m1_req = 1'b1; m1_addr = 32'h40; m1_we = 4'h0;
        settle();
        check("bw_m0_ack", m0_ack, 1'b1);
        check("bw_m1_ack", m1_ack, 1'b0);
        check("bw_dwe", s_dwe, 4'b0010);
        check("bw_addr", s_daddr, 32'h10);
        next_cycle();
        m0_req = 1'b0; m0_we = 4'h0; m1_req = 1'b0;
        next_cycle();
        check("bw_mem10", mem[4], 32'h1234_AB78);

        // Locked 12-beat M1 write burst against a continuous M0 reader.
        beat   = 0;
        m0_req = 1'b1; m0_addr = 32'h10;
        m1_req = 1'b1; m1_lock = 1'b1; m1_we = 4'hF;
        for (int c = 0; c < 20; c++) begin
            m1_addr  = 32'h200 + 32'(4 * beat);
            m1_wdata = 32'hB000_0000 + 32'(beat + 1);
            settle();
            exp_m1 = ((c >= 4) && (c <= 11)) || ((c >= 16) && (c <= 19));
            check("burst_m1_ack", m1_ack, exp_m1);
            check("burst_m0_ack", m0_ack, !exp_m1);
            if (m1_ack) beat++;
            next_cycle();
        end
        check("burst_beats", beat, 12);
        m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0; m1_we = 4'h0;
        next_cycle();
        next_cycle();
        next_cycle();
        for (int i = 0; i < 12; i++) begin
            check("burst_mem", mem[128 + i], 32'hB000_0000 + 32'(i + 1));
        end

        // Reset on beat 3 of a locked burst drops that beat.
        m1_req = 1'b1; m1_lock = 1'b1; m1_we = 4'hF;
        for (int b = 0; b < 2; b++) begin
            m1_addr  = 32'h300 + 32'(4 * b);
            m1_wdata = 32'hC0 + 32'(b + 1);
            settle();
            check("abort_pre_ack", m1_ack, 1'b1);
            next_cycle();
        end
        m1_addr = 32'h308; m1_wdata = 32'hC3; reset = 1'b0;
        settle();
        check("abort_m1_ack", m1_ack, 1'b0);
        check("abort_dwe", s_dwe, 4'h0);
        check("abort_owner", owner, 2'b00);
        next_cycle();
        reset  = 1'b1;
        m1_req = 1'b0; m1_lock = 1'b0; m1_we = 4'h0;
        m0_req = 1'b1; m0_addr = 32'h10; m0_we = 4'h0;
        settle();
        check("post_m0_ack", m0_ack, 1'b1);
        check("post_owner", owner, 2'b01);
        check("post_rdata", m0_rdata, 32'h1234_AB78);
        next_cycle();
        m0_req = 1'b0;
        next_cycle();
        check("abort_mem_b1", mem[192], 32'hC1);
        check("abort_mem_b2", mem[193], 32'hC2);
        check("abort_mem_b3", mem[194], 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
